// File: rtl/huffman_encoder_packer.sv
// Huffman prefix encoder for signed 4-bit symbols, packing code bits MSB-first into chunks.
// Optional statistics counters are enabled with `define HUFF_ENC_STATS_EN.
module huffman_encoder_packer #(
  parameter int MAX_CODE = 9,
  parameter int CHUNK_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic signed [3:0] sym,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              flush,
  output logic [3:0]        out_bits,
  output logic [2:0]        out_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              flush_done
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [15:0]       sym_count,
  output logic [19:0]       bit_count_total
`endif
);

  localparam int         BUF_W   = MAX_CODE + CHUNK_W - 1;
  localparam logic [3:0] CHUNK_C = 4'(CHUNK_W);
  localparam logic [3:0] ACC_LIM = 4'(BUF_W - MAX_CODE);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Returns {len[3:0], code[8:0]} with the code left-aligned in 9 bits.
  function automatic logic [12:0] encode(input logic signed [3:0] s);
    logic [3:0] mag;
    logic [8:0] code;
    logic [3:0] len;
    mag = s[3] ? 4'(-s) : 4'(s);
    if (s == 4'sd0) begin
      code = 9'd0;
      len  = 4'd1;
    end else if (s == -4'sd8) begin
      code = 9'b111111110;
      len  = 4'd9;
    end else begin
      code = ~(9'h1FF >> mag);
      code = code | (s[3] ? (9'h100 >> (mag + 4'd1)) : 9'h000);
      len  = mag + 4'd2;
    end
    return {len, code};
  endfunction

`ifdef HUFF_ENC_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic logic [19:0] sat_add20(input logic [19:0] x, input logic [3:0] l);
    logic [20:0] sum;
    sum = {1'b0, x} + 21'(l);
    return sum[20] ? 20'hFFFFF : sum[19:0];
  endfunction
`endif

  logic [BUF_W-1:0]   acc, acc_a, acc_n;
  logic [3:0]         cnt, cnt_a, cnt_n;
  logic [1:0]         state, state_n;
  logic [12:0]        enc;
  logic [3:0]         enc_len;
  logic [BUF_W-1:0]   code_wide;
  logic [CHUNK_W-1:0] chunk;
  logic               can_load, emit_full, emit_part, accept;

  assign enc       = encode(sym);
  assign enc_len   = enc[12:9];
  assign code_wide = BUF_W'(enc[8:0]) << (BUF_W - 9);
  assign chunk     = acc[BUF_W-1 -: CHUNK_W];

  assign sym_ready  = (state == ST_RUN) && (cnt <= ACC_LIM);
  assign accept     = sym_valid && sym_ready;
  assign can_load   = !out_valid || out_ready;
  assign emit_full  = can_load && (cnt >= CHUNK_C);
  assign emit_part  = can_load && (state == ST_FLUSH) && (cnt != 4'd0) && (cnt < CHUNK_C);
  assign flush_done = (state == ST_DONE);

  // Drain first, then append the new code directly below the remaining bits.
  always_comb begin
    acc_a = acc;
    cnt_a = cnt;
    if (emit_full) begin
      acc_a = acc << CHUNK_W;
      cnt_a = cnt - CHUNK_C;
    end else if (emit_part) begin
      acc_a = '0;
      cnt_a = 4'd0;
    end
    acc_n = acc_a;
    cnt_n = cnt_a;
    if (accept) begin
      acc_n = acc_a | (code_wide >> cnt_a);
      cnt_n = cnt_a + enc_len;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_RUN:   if (flush) state_n = ST_FLUSH;
      ST_FLUSH: if ((cnt == 4'd0) && can_load) state_n = ST_DONE;
      ST_DONE:  state_n = ST_RUN;
      default:  state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      cnt       <= 4'd0;
      state     <= ST_RUN;
      out_valid <= 1'b0;
      out_bits  <= 4'd0;
      out_len   <= 3'd0;
    end else begin
      acc   <= acc_n;
      cnt   <= cnt_n;
      state <= state_n;
      if (emit_full) begin
        out_bits  <= 4'(chunk);
        out_len   <= 3'(CHUNK_W);
        out_valid <= 1'b1;
      end else if (emit_part) begin
        out_bits  <= 4'(chunk >> (CHUNK_C - cnt));
        out_len   <= cnt[2:0];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef HUFF_ENC_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_count       <= 16'd0;
      bit_count_total <= 20'd0;
    end else if (accept) begin
      sym_count       <= sat_inc16(sym_count);
      bit_count_total <= sat_add20(bit_count_total, enc_len);
    end
  end
`endif

endmodule

// File: tb/tb_huffman_encoder_packer.sv
// Self-checking bench for huffman_encoder_packer: bit-level scoreboard plus a loopback decoder.
module tb_huffman_encoder_packer;

  logic              clk = 1'b0;
  logic              reset_n;
  logic signed [3:0] sym;
  logic              sym_valid;
  logic              sym_ready;
  logic              flush;
  logic [3:0]        out_bits;
  logic [2:0]        out_len;
  logic              out_valid;
  logic              out_ready;
  logic              flush_done;
`ifdef HUFF_ENC_STATS_EN
  logic [15:0]       sym_count;
  logic [19:0]       bit_count_total;
`endif

  huffman_encoder_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sym        (sym),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .flush      (flush),
    .out_bits   (out_bits),
    .out_len    (out_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_done (flush_done)
`ifdef HUFF_ENC_STATS_EN
    ,
    .sym_count       (sym_count),
    .bit_count_total (bit_count_total)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_chunks = 0;
  int n_done   = 0;
  int bits_out = 0;
  int n_dec    = 0;
  logic [3:0] last_bits;
  logic [2:0] last_len;
  bit   bq[$];
  bit   dq[$];
  int   sq[$];
  bit   loop_en    = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_fixed = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference code table, written out bit by bit.
  task automatic push_code(input logic signed [3:0] s);
    int k;
    if (s == 0) bq.push_back(1'b0);
    else if (s == -8) begin
      for (int i = 0; i < 8; i++) bq.push_back(1'b1);
      bq.push_back(1'b0);
    end else begin
      k = (s < 0) ? -int'(s) : int'(s);
      for (int i = 0; i < k; i++) bq.push_back(1'b1);
      bq.push_back(1'b0);
      bq.push_back(s < 0);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  always @(negedge clk) begin : mon
    int exp_len;
    logic [3:0] exp_bits;
    int k, nb, dv, es;
    bit progress;
    if (reset_n && out_valid && out_ready) begin
      exp_len = (bq.size() >= 4) ? 4 : bq.size();
      exp_bits = 4'd0;
      for (int i = 0; i < int'(out_len); i++)
        if (bq.size() > 0) exp_bits = {exp_bits[2:0], bq.pop_front()};
      check_eq("chunk_len", 32'(out_len), 32'(exp_len));
      check_eq("chunk_bits", 32'(out_bits), 32'(exp_bits));
      n_chunks++;
      bits_out += int'(out_len);
      last_bits = out_bits;
      last_len  = out_len;
      if (loop_en) begin
        for (int i = int'(out_len) - 1; i >= 0; i--) dq.push_back(out_bits[i]);
        progress = 1'b1;
        while (progress) begin
          progress = 1'b0;
          k = 0;
          while (k < dq.size() && k < 8 && dq[k]) k++;
          if (k < dq.size()) begin
            if (k == 0) begin dv = 0; nb = 1; progress = 1'b1; end
            else if (k == 8) begin dv = -8; nb = 9; progress = 1'b1; end
            else if (dq.size() >= k + 2) begin
              dv = dq[k+1] ? -k : k; nb = k + 2; progress = 1'b1;
            end
            if (progress) begin
              repeat (nb) void'(dq.pop_front());
              n_dec++;
              es = (sq.size() > 0) ? sq.pop_front() : 99;
              check_eq("loop_sym", 32'(dv), 32'(es));
            end
          end
        end
      end
    end
    if (reset_n && sym_valid && sym_ready) begin
      push_code(sym);
      if (loop_en) sq.push_back(int'(sym));
    end
    if (reset_n && flush_done) begin
      n_done++;
      check_eq("done_buf_empty", 32'(bq.size()), 32'd0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [3:0] s);
    bit got = 1'b0;
    sym = s;
    sym_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sym_ready) begin got = 1'b1; break; end
    end
    if (!got) check_eq("send_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
  endtask

  task automatic do_flush();
    bit got = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (flush_done) begin got = 1'b1; break; end
    end
    check_eq("flush_done_seen", 32'(got), 32'd1);
    cycles(1);
  endtask

  initial begin
    int c0, d0, b0;
    reset_n = 1'b0; sym = 4'sd0; sym_valid = 1'b0; flush = 1'b0;
    cycles(3);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_bits", 32'(out_bits), 32'd0);
    check_eq("rst_out_len", 32'(out_len), 32'd0);
    check_eq("rst_flush_done", 32'(flush_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(1);
    check_eq("rst_sym_ready", 32'(sym_ready), 32'd1);

    // +2 alone fills exactly one chunk
    c0 = n_chunks;
    send(4'sd2);
    cycles(5);
    check_eq("t1_chunks", 32'(n_chunks - c0), 32'd1);
    check_eq("t1_bits", 32'(last_bits), 32'b1100);
    check_eq("t1_len", 32'(last_len), 32'd4);
    check_eq("t1_idle", 32'(out_valid), 32'd0);

    // -7 then flush: two full chunks and a 1-bit tail
    c0 = n_chunks; d0 = n_done;
    send(-4'sd7);
    do_flush();
    check_eq("t2_chunks", 32'(n_chunks - c0), 32'd3);
    check_eq("t2_bits", 32'(last_bits), 32'b0001);
    check_eq("t2_len", 32'(last_len), 32'd1);
    check_eq("t2_done_once", 32'(n_done - d0), 32'd1);

    // 0 then flush, then an empty flush
    c0 = n_chunks;
    send(4'sd0);
    do_flush();
    check_eq("t3_chunks", 32'(n_chunks - c0), 32'd1);
    check_eq("t3_bits", 32'(last_bits), 32'b0000);
    check_eq("t3_len", 32'(last_len), 32'd1);
    c0 = n_chunks; d0 = n_done;
    do_flush();
    check_eq("t3_empty_chunks", 32'(n_chunks - c0), 32'd0);
    check_eq("t3_empty_done", 32'(n_done - d0), 32'd1);

    // backpressure with +3 stream
    ready_fixed = 1'b0;
    cycles(2);
    b0 = bits_out;
    send(4'sd3);
    send(4'sd3);
    sym = 4'sd3;
    sym_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("t4_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t4_hold_bits", 32'(out_bits), 32'b1110);
      check_eq("t4_hold_len", 32'(out_len), 32'd4);
      check_eq("t4_sym_ready_low", 32'(sym_ready), 32'd0);
    end
    cycles(1);
    ready_fixed = 1'b1;
    repeat (6) send(4'sd3);
    do_flush();
    check_eq("t4_total_bits", 32'(bits_out - b0), 32'd40);

    // asynchronous reset with cnt=6 and a held chunk
    ready_fixed = 1'b0;
    cycles(2);
    send(4'sd3);
    send(4'sd3);
    cycles(2);
    check_eq("t5_pre_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_bits", 32'(out_bits), 32'd0);
    check_eq("t5_rst_len", 32'(out_len), 32'd0);
    check_eq("t5_rst_done", 32'(flush_done), 32'd0);
    bq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    ready_fixed = 1'b1;
    cycles(2);
    check_eq("t5_sym_ready", 32'(sym_ready), 32'd1);
    send(4'sd1);
    do_flush();
    check_eq("t5_bits", 32'(last_bits), 32'b0100);
    check_eq("t5_len", 32'(last_len), 32'd3);

    // random loopback with periodic flushes
    dq.delete(); sq.delete(); n_dec = 0;
    loop_en = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(4'($urandom_range(0, 15)));
      if (i % 37 == 36) do_flush();
    end
    do_flush();
    rand_ready = 1'b0;
    cycles(2);
    check_eq("t6_decoded", 32'(n_dec), 32'd1000);
    check_eq("t6_leftover_syms", 32'(sq.size()), 32'd0);
    check_eq("t6_leftover_bits", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
